// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: operation select, control FSM states
// and the signed-overflow helper used by both the binary and decimal paths.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALUTXA, ALUTXB, ALUADD, ALUSUB, ALUAND, ALUORA, ALUEOR,
    ALUROL, ALUROR, ALUBIT, ALUASL, ALULSR, ALUMUL
  } ALUXFunc;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ALUState;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic ovf_rule(input logic a_msb, input logic b_msb, input logic r_msb);
    return ~(a_msb ^ b_msb) & (a_msb ^ r_msb);
  endfunction

endpackage

// File: rtl/alu_bcd_digit.sv
// One BCD nibble of a decimal add or subtract. For subtract, c_i/c_o are
// borrows. ovf_o is taken from the uncorrected nibble result.
module alu_bcd_digit
  import alu_mc_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sub_i,
  input  logic       c_i,
  output logic [3:0] d_o,
  output logic       c_o,
  output logic       ovf_o
);

  logic [4:0] raw;

  // Raw binary nibble result, then decimal correction.
  always_comb begin
    if (sub_i) begin
      raw = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, c_i};
    end else begin
      raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    end
    d_o = raw[3:0];
    c_o = 1'b0;
    if (sub_i) begin
      // raw[4] set means the difference went negative
      if (raw[4]) begin
        d_o = raw[3:0] - 4'd6;
        c_o = 1'b1;
      end
    end else if (raw > 5'd9) begin
      d_o = raw[3:0] + 4'd6;
      c_o = 1'b1;
    end
    ovf_o = ovf_rule(a_i[3], sub_i ? ~b_i[3] : b_i[3], raw[3]);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Binary ops take one iteration,
// BCD add/sub run one nibble per cycle, shifts/rotates one bit per cycle.
// Define ALU_MUL_EN to build the shift-add multiplier for ALUMUL; otherwise
// ALUMUL returns zero in one iteration and no multiplier is built.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  ALUXFunc        in_func,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_cin,
  input  logic           in_cinclr,
  input  logic           in_dec,
  input  logic [SHW-1:0] in_shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [W-1:0]   out_hi,
  output logic           out_cout,
  output logic           out_zero,
  output logic           out_sign,
  output logic           out_ovf
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned ND = W / 4;

  ALUState       state_q;
  ALUXFunc       func_q;
  logic [W-1:0]  a_q, b_q, acc_q, hi_q;
  logic          c_q, dec_q, noop_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q, out_valid_q;
  logic [W-1:0]  out_data_q, out_hi_q;
  logic          out_cout_q, out_zero_q, out_sign_q, out_ovf_q;

  logic          cin_eff, c_init, is_sub;
  logic [CW-1:0] n_init;

  assign is_sub = (func_q == ALUSUB);

  // Decode effective carry-in and iteration count of the incoming request.
  always_comb begin
    cin_eff = in_cin & ~in_cinclr;
    // decimal subtract tracks a borrow, so carry-in set means no borrow
    c_init  = (in_func == ALUSUB && in_dec) ? ~cin_eff : cin_eff;
    case (in_func)
      ALUADD, ALUSUB: n_init = in_dec ? CW'(ND) : CW'(1);
      ALUROL, ALUROR, ALUASL, ALULSR: n_init = (in_shamt == '0) ? CW'(1) : CW'(in_shamt);
`ifdef ALU_MUL_EN
      ALUMUL: n_init = CW'(W);
`endif
      default: n_init = CW'(1);
    endcase
  end

  logic [3:0] dig_d;
  logic       dig_c, dig_ovf;

  alu_bcd_digit u_digit (
    .a_i  (a_q[3:0]),
    .b_i  (b_q[3:0]),
    .sub_i(is_sub),
    .c_i  (c_q),
    .d_o  (dig_d),
    .c_o  (dig_c),
    .ovf_o(dig_ovf)
  );

  logic [W-1:0] a_nx, b_nx, acc_nx, hi_nx, bop;
  logic [W:0]   sum;
  logic         c_nx, cout_nx, zero_nx, sign_nx, ovf_nx;
`ifdef ALU_MUL_EN
  logic [W:0]   psum;
`endif

  // One iteration of the selected operation plus the flags it would retire with.
  always_comb begin
    a_nx   = a_q;
    b_nx   = b_q;
    acc_nx = acc_q;
    hi_nx  = hi_q;
    c_nx   = c_q;
    ovf_nx = 1'b0;
    bop    = is_sub ? ~b_q : b_q;
    sum    = {1'b0, a_q} + {1'b0, bop} + {{W{1'b0}}, is_sub ? ~c_q : c_q};
`ifdef ALU_MUL_EN
    psum   = {1'b0, hi_q} + {1'b0, acc_q[0] ? b_q : {W{1'b0}}};
`endif
    case (func_q)
      ALUTXA:         acc_nx = a_q;
      ALUTXB:         acc_nx = b_q;
      ALUAND, ALUBIT: acc_nx = a_q & b_q;
      ALUORA:         acc_nx = a_q | b_q;
      ALUEOR:         acc_nx = a_q ^ b_q;
      ALUADD, ALUSUB: begin
        if (dec_q) begin
          // operands drain low nibble first; result fills from the top
          a_nx   = a_q >> 4;
          b_nx   = b_q >> 4;
          acc_nx = {dig_d, acc_q[W-1:4]};
          c_nx   = dig_c;
          ovf_nx = dig_ovf;
        end else begin
          acc_nx = sum[W-1:0];
          c_nx   = is_sub ? ~sum[W] : sum[W];
          ovf_nx = ovf_rule(a_q[W-1], bop[W-1], sum[W-1]);
        end
      end
      ALUROL: if (!noop_q) {c_nx, acc_nx} = {acc_q, c_q};
      ALUROR: if (!noop_q) {acc_nx, c_nx} = {c_q, acc_q};
      ALUASL: if (!noop_q) {c_nx, acc_nx} = {acc_q, 1'b0};
      ALULSR: if (!noop_q) {acc_nx, c_nx} = {1'b0, acc_q};
      ALUMUL: begin
`ifdef ALU_MUL_EN
        // acc holds the remaining multiplier bits, product shifts in from hi
        {hi_nx, acc_nx} = {psum, acc_q[W-1:1]};
`else
        acc_nx = '0;
        hi_nx  = '0;
`endif
      end
      default: ;
    endcase
    cout_nx = (dec_q && is_sub) ? ~c_nx : c_nx;
    zero_nx = (acc_nx == '0);
    sign_nx = acc_nx[W-1];
    if (func_q == ALUBIT) begin
      sign_nx = b_q[W-1];
      ovf_nx  = b_q[W-2];
    end
    if (func_q == ALUMUL) begin
      zero_nx = ({hi_nx, acc_nx} == '0);
      sign_nx = hi_nx[W-1];
      ovf_nx  = (hi_nx != '0);
    end
  end

  // Control FSM with working registers and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      func_q      <= ALUTXA;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      c_q         <= 1'b0;
      dec_q       <= 1'b0;
      noop_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hi_q    <= '0;
      out_cout_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_sign_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            func_q     <= in_func;
            a_q        <= in_a;
            b_q        <= in_b;
            acc_q      <= in_a;
            hi_q       <= '0;
            c_q        <= c_init;
            dec_q      <= in_dec;
            noop_q     <= (in_shamt == '0);
            cnt_q      <= n_init;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          a_q   <= a_nx;
          b_q   <= b_nx;
          acc_q <= acc_nx;
          hi_q  <= hi_nx;
          c_q   <= c_nx;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_data_q  <= acc_nx;
            out_hi_q    <= hi_nx;
            out_cout_q  <= cout_nx;
            out_zero_q  <= zero_nx;
            out_sign_q  <= sign_nx;
            out_ovf_q   <= ovf_nx;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hi    = out_hi_q;
  assign out_cout  = out_cout_q;
  assign out_zero  = out_zero_q;
  assign out_sign  = out_sign_q;
  assign out_ovf   = out_ovf_q;

endmodule
